isram_fetch_arb: RTL and testbench
==================================

// Module: isram_fetch_arb
// PURPOSE
//  Single-port arbiter and sequencer for the 64-bit instruction SRAM. Sits between genpc/fetch and the ISRAM macro.
//  Shares the port between instruction fetch and the load/store ISRAM window, and owns the two-beat
//  cross-8-byte-boundary fetch sequence. Reassembles the 32-bit instruction at any halfword PC and keeps a
//  one-line buffer, so repeated fetches from the same line do not access the SRAM.
// PARAMETERS
//  LS_STREAK_MAX  4  max consecutive ls grants while fe_req is pending; fetch then wins the next contention
//  BUF_EN         1  1 = line buffer enabled; 0 = every fetch reads the SRAM
// PORTS
//  clk           in   1   clock, rising edge
//  cpurst_n      in   1   reset, asynchronous, active-low
//  fe_req        in   1   fetch request; held with fe_pc until fe_gnt
//  fe_pc         in   31  fetch address [31:1], halfword aligned
//  fe_flush      in   1   cancel the in-flight fetch (redirect)
//  fe_gnt        out  1   fetch accepted this cycle (combinational)
//  fe_vld        out  1   fe_instr valid
//  fe_instr      out  32  instruction bits at the granted fe_pc
//  ls_req        in   1   load/store request; held with attributes until ls_gnt
//  ls_we         in   1   1 = write
//  ls_adr        in   29  line address [31:3]
//  ls_be         in   8   write byte enables
//  ls_wdata      in   64  write data
//  ls_gnt        out  1   ls accepted this cycle (combinational)
//  ls_rvld       out  1   ls_rdata valid (reads only)
//  ls_rdata      out  64  read data
//  isram_cs      out  1   SRAM select
//  isram_we      out  1   SRAM write
//  isram_adr     out  29  SRAM line address [31:3]
//  isram_be      out  8   SRAM byte enables
//  isram_wdata   out  64  SRAM write data
//  isram_rdata   in   64  SRAM read data, valid the cycle after a read select
// BEHAVIOUR
//  - Reset: state IDLE; line buffer invalid; streak counter 0.
//    fe_gnt, fe_vld, ls_gnt, ls_rvld, isram_cs and isram_we are 0. fe_instr and ls_rdata are 0.
//  - SRAM protocol: one access per cycle; read data returns at T+1.
//  - Arbitration runs only when the port is free (not in FE_HI), on the current-cycle requests:
//    ls wins by default; fetch wins when streak == LS_STREAK_MAX.
//  - Streak counter: +1 per ls grant while fe_req=1 (saturates); cleared on fe_gnt or when fe_req=0.
//  - Fetch PC decode: lo = fe_pc[31:3], hi = lo+1 (29-bit wrap), off = fe_pc[2:1].
//  - Fetch, off != 3 (single line):
//    - buffer hit on lo: no SRAM access.
//    - miss: read lo.
//    - Either way fe_vld at G+1; fe_instr = line[16*off +: 32].
//  - Fetch, off == 3 (crosses the 8-byte boundary):
//    - buffer hit on lo: read hi at G; fe_vld at G+1.
//    - miss: state FE_HI.
//      - G: read lo.
//      - G+1: capture lo into the buffer, read hi; port busy, fe_gnt=ls_gnt=0.
//      - G+2: fe_vld. Latency 2.
//    - fe_instr = {hi[15:0], lo[63:48]}.
//  - Buffer: loads with the last fetch line read (hi for a cross fetch).
//    - Invalidated in the cycle an ls write hits buf_adr.
//    - ls reads never fill it.
//    - BUF_EN=0: never valid.
//  - ls: the write is issued at grant and has no response. A read gives ls_rvld at G+1, ls_rdata = isram_rdata.
//  - fe_flush:
//    - Suppresses any fe_vld in that cycle.
//    - In FE_HI: hi read not issued, state -> IDLE, and the port is arbitrated that same cycle.
//    - fe_flush with fe_req in the same cycle: the request is the redirect target and is eligible for grant.
//  - fe_vld and ls_rvld are never 1 in the same cycle.
//  - Reset asserted mid-sequence: immediate return to the reset state; no response is delivered.
// STRUCTURE
//  - Shared package isram_pkg:
//    - state enum {IDLE, FE_HI}
//    - ISRAM_LINE_W=64, ISRAM_ADR_W=29, HW_OFF_CROSS=2'b11
//  - One sub-module, isram_line_buf:
//    - holds buf_vld, buf_adr, buf_data
//    - ports: hit compare, fill, write-invalidate
//  - Arbiter, FSM, streak counter and the realign mux stay in the top level.
// TESTING
//  1. pc 0x100, miss, then pc 0x104 -> one SRAM read at 0x20; fe_vld twice; the second is a buffer hit, isram_cs=0.
//  2. pc 0x206, empty buffer -> reads 0x40 then 0x41; fe_vld at G+2; fe_instr = {rd41[15:0], rd40[63:48]}.
//  3. pc 0x206 with line 0x40 buffered -> single read 0x41; fe_vld at G+1.
//  4. ls_req and fe_req high for 10 cycles, LS_STREAK_MAX=4 -> grant pattern ls,ls,ls,ls,fe repeating.
//  5. fe_flush in FE_HI with ls_req=1 -> no hi read, no fe_vld; ls_gnt in the same cycle.
//  6. Buffered line 0x20, ls write 0x20 be=0x0F, then fetch pc 0x100 -> buffer miss; fetch returns the new data.

Source files
------------

// File: rtl/isram_fetch_arb_pkg.sv
// Shared types and constants for the instruction-SRAM fetch arbiter slice.
//   state_t      : arbiter sequencer state (IDLE, FE_HI)
//   line_adr_t   : 29-bit SRAM line address [31:3]
//   line_t       : 64-bit SRAM line
//   realign()    : extracts the 32-bit instruction at a halfword offset
package isram_pkg;

    localparam int         ISRAM_LINE_W = 64;
    localparam int         ISRAM_ADR_W  = 29;
    localparam logic [1:0] HW_OFF_CROSS = 2'b11;

    typedef enum logic {
        IDLE,
        FE_HI
    } state_t;

    typedef logic [ISRAM_ADR_W-1:0]  line_adr_t;
    typedef logic [ISRAM_LINE_W-1:0] line_t;

    // Instruction at halfword offset 'off' of the line pair {hi, lo}. Offsets
    // 0..2 stay inside lo; offset 3 takes lo[63:48] and hi[15:0].
    function automatic logic [31:0] realign(input line_t lo, input line_t hi,
                                            input logic [1:0] off);
        logic [2*ISRAM_LINE_W-1:0] pair;
        pair = {hi, lo};
        return pair[{1'b0, off, 4'b0000} +: 32];
    endfunction

endpackage

// File: rtl/isram_fetch_arb_if.sv
// Bus bundle around the ISRAM fetch arbiter.
//   fe_*    : fetch request/grant and instruction return
//   ls_*    : load/store window request/grant and read return
//   isram_* : single-port SRAM macro interface
// Modports: slave = the arbiter, master = the clients plus the SRAM macro.
interface isram_fetch_arb_if;
    import isram_pkg::*;

    logic        fe_req;
    logic [30:0] fe_pc;
    logic        fe_flush;
    logic        fe_gnt;
    logic        fe_vld;
    logic [31:0] fe_instr;

    logic        ls_req;
    logic        ls_we;
    line_adr_t   ls_adr;
    logic [7:0]  ls_be;
    line_t       ls_wdata;
    logic        ls_gnt;
    logic        ls_rvld;
    line_t       ls_rdata;

    logic        isram_cs;
    logic        isram_we;
    line_adr_t   isram_adr;
    logic [7:0]  isram_be;
    line_t       isram_wdata;
    line_t       isram_rdata;

    modport slave (
        input  fe_req, fe_pc, fe_flush, ls_req, ls_we, ls_adr, ls_be, ls_wdata,
               isram_rdata,
        output fe_gnt, fe_vld, fe_instr, ls_gnt, ls_rvld, ls_rdata,
               isram_cs, isram_we, isram_adr, isram_be, isram_wdata
    );

    modport master (
        output fe_req, fe_pc, fe_flush, ls_req, ls_we, ls_adr, ls_be, ls_wdata,
               isram_rdata,
        input  fe_gnt, fe_vld, fe_instr, ls_gnt, ls_rvld, ls_rdata,
               isram_cs, isram_we, isram_adr, isram_be, isram_wdata
    );

endinterface

// File: rtl/isram_line_buf.sv
// One-line fetch buffer in front of the ISRAM.
//   lk_adr / lk_hit            : combinational hit compare against the held line
//   buf_data                   : held line contents
//   fill_en/fill_adr/fill_data : load a fetched line (end of cycle)
//   inv_en/inv_adr             : ls write this cycle; drops the line if it matches
// With BUF_EN = 0 the buffer never becomes valid.
module isram_line_buf
    import isram_pkg::*;
#(
    parameter bit BUF_EN = 1'b1
) (
    input  logic      clk,
    input  logic      cpurst_n,
    input  line_adr_t lk_adr,
    output logic      lk_hit,
    output line_t     buf_data,
    input  logic      fill_en,
    input  line_adr_t fill_adr,
    input  line_t     fill_data,
    input  logic      inv_en,
    input  line_adr_t inv_adr
);

    logic      buf_vld;
    line_adr_t buf_adr;

    // A write landing in the same cycle as a fill of that line means the fill
    // data predates the write, so the line is loaded but left invalid.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            buf_vld <= 1'b0;
        end else if (!BUF_EN) begin
            buf_vld <= 1'b0;
        end else if (fill_en) begin
            buf_vld <= !(inv_en && (inv_adr == fill_adr));
        end else if (inv_en && (inv_adr == buf_adr)) begin
            buf_vld <= 1'b0;
        end
    end

    // NOTE: address and data are storage qualified by buf_vld, so they carry
    // no reset; only the valid bit must come out of reset cleared.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            buf_adr  <= fill_adr;
            buf_data <= fill_data;
        end
    end

    assign lk_hit = buf_vld && (buf_adr == lk_adr);

endmodule

// File: rtl/isram_fetch_arb.sv
// Single-port arbiter and sequencer for the 64-bit instruction SRAM.
// Shares the port between instruction fetch and the load/store window, runs
// the two-beat fetch for instructions straddling an 8-byte line, realigns the
// 32-bit instruction at any halfword PC and keeps a one-line fetch buffer.
//   clk, cpurst_n : clock, async active-low reset
//   bus (slave)   : fe_* fetch port, ls_* load/store port, isram_* SRAM macro
// Parameters:
//   LS_STREAK_MAX : consecutive ls grants allowed while a fetch waits
//   BUF_EN        : 1 enables the line buffer
module isram_fetch_arb
    import isram_pkg::*;
#(
    parameter int unsigned LS_STREAK_MAX = 4,
    parameter bit          BUF_EN        = 1'b1
) (
    input logic               clk,
    input logic               cpurst_n,
    isram_fetch_arb_if.slave  bus
);

    localparam int SW = (LS_STREAK_MAX < 1) ? 1 : $clog2(LS_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(LS_STREAK_MAX);

    state_t        state;
    logic          run_q;        // low for the first cycle after reset: no grants
    logic [SW-1:0] streak;
    line_adr_t     hi_adr_q;
    line_adr_t     fill_adr_q;
    logic [1:0]    off_q;
    logic          fe_pend_q;    // a fetch response is due this cycle
    logic          fe_sram_q;    // single-line response comes from isram_rdata
    logic          ls_pend_q;    // an ls read response is due this cycle
    logic          fill_pend_q;  // isram_rdata this cycle is a fetch line
    line_t         lo_q;         // low line of the pending fetch

    // Fetch PC decode
    line_adr_t  pc_lo;
    line_adr_t  pc_hi;
    logic [1:0] pc_off;
    logic       pc_cross;

    assign pc_lo    = bus.fe_pc[30:2];
    assign pc_hi    = pc_lo + line_adr_t'(1);
    assign pc_off   = bus.fe_pc[1:0];
    assign pc_cross = (pc_off == HW_OFF_CROSS);

    logic  buf_hit;
    line_t buf_data;

    isram_line_buf #(
        .BUF_EN (BUF_EN)
    ) u_line_buf (
        .clk       (clk),
        .cpurst_n  (cpurst_n),
        .lk_adr    (pc_lo),
        .lk_hit    (buf_hit),
        .buf_data  (buf_data),
        .fill_en   (fill_pend_q),
        .fill_adr  (fill_adr_q),
        .fill_data (bus.isram_rdata),
        .inv_en    (bus.ls_gnt && bus.ls_we),
        .inv_adr   (bus.ls_adr)
    );

    // Arbitration. A flush in FE_HI drops the hi beat and frees the port in
    // the same cycle.
    logic hi_rd_now;
    logic port_free;
    logic fe_first;
    logic ls_win;
    logic fe_split;

    assign hi_rd_now = (state == FE_HI) && !bus.fe_flush;
    assign port_free = run_q && !hi_rd_now;
    assign fe_first  = bus.fe_req && (streak == STREAK_MAX);
    assign ls_win    = bus.ls_req && !fe_first;
    assign bus.ls_gnt = port_free && ls_win;
    assign bus.fe_gnt = port_free && bus.fe_req && !ls_win;
    assign fe_split  = bus.fe_gnt && pc_cross && !buf_hit;

    // SRAM port mux
    // NOTE: every output gets a default before the branches so no path leaves
    // a value held, which would otherwise infer a latch.
    always_comb begin
        bus.isram_cs    = 1'b0;
        bus.isram_we    = 1'b0;
        bus.isram_adr   = '0;
        bus.isram_be    = '0;
        bus.isram_wdata = '0;
        if (hi_rd_now) begin
            bus.isram_cs  = 1'b1;
            bus.isram_adr = hi_adr_q;
        end else if (bus.ls_gnt) begin
            bus.isram_cs  = 1'b1;
            bus.isram_we  = bus.ls_we;
            bus.isram_adr = bus.ls_adr;
            if (bus.ls_we) begin
                bus.isram_be    = bus.ls_be;
                bus.isram_wdata = bus.ls_wdata;
            end
        end else if (bus.fe_gnt) begin
            // Cross fetch with lo buffered reads hi now; otherwise a miss reads lo.
            bus.isram_cs  = pc_cross || !buf_hit;
            bus.isram_adr = (pc_cross && buf_hit) ? pc_hi : pc_lo;
        end
    end

    // Sequencer, streak counter and response pipeline
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state       <= IDLE;
            run_q       <= 1'b0;
            streak      <= '0;
            hi_adr_q    <= '0;
            fill_adr_q  <= '0;
            off_q       <= '0;
            fe_pend_q   <= 1'b0;
            fe_sram_q   <= 1'b0;
            ls_pend_q   <= 1'b0;
            fill_pend_q <= 1'b0;
            lo_q        <= '0;
        end else begin
            run_q <= 1'b1;
            state <= fe_split ? FE_HI : IDLE;

            if (!bus.fe_req || bus.fe_gnt) begin
                streak <= '0;
            end else if (bus.ls_gnt && (streak != STREAK_MAX)) begin
                streak <= streak + SW'(1);
            end

            fe_pend_q   <= (bus.fe_gnt && !fe_split) || hi_rd_now;
            ls_pend_q   <= bus.ls_gnt && !bus.ls_we;
            fill_pend_q <= (bus.fe_gnt && (pc_cross || !buf_hit)) || hi_rd_now;

            if (hi_rd_now) begin
                fill_adr_q <= hi_adr_q;
            end else if (bus.fe_gnt) begin
                fill_adr_q <= (pc_cross && buf_hit) ? pc_hi : pc_lo;
            end

            if (bus.fe_gnt) begin
                off_q     <= pc_off;
                hi_adr_q  <= pc_hi;
                fe_sram_q <= !buf_hit && !pc_cross;
            end

            if (bus.fe_gnt && buf_hit) begin
                lo_q <= buf_data;
            end else if (state == FE_HI) begin
                lo_q <= bus.isram_rdata;
            end
        end
    end

    // Responses
    assign bus.fe_vld   = fe_pend_q && !bus.fe_flush;
    assign bus.fe_instr = bus.fe_vld
                        ? realign(fe_sram_q ? bus.isram_rdata : lo_q, bus.isram_rdata, off_q)
                        : '0;
    assign bus.ls_rvld  = ls_pend_q;
    assign bus.ls_rdata = ls_pend_q ? bus.isram_rdata : '0;

endmodule

// File: tb/tb_isram_fetch_arb.sv
// Directed bench for isram_fetch_arb with an SRAM model, a reference memory
// and scoreboard queues for fetch and ls read returns.
module tb_isram_fetch_arb;
    import isram_pkg::*;

    logic clk = 1'b0;
    logic cpurst_n = 1'b0;

    isram_fetch_arb_if bus();

    isram_fetch_arb #(
        .LS_STREAK_MAX (4),
        .BUF_EN        (1'b1)
    ) dut (
        .clk      (clk),
        .cpurst_n (cpurst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // ---------------- memories ----------------
    logic [63:0] sram    [1024];
    bit          sram_wr [1024];
    logic [63:0] ref_mem [1024];
    bit          ref_wr  [1024];

    function automatic logic [63:0] init_line(input logic [9:0] a);
        logic [15:0] h;
        h = {6'b0, a};
        return {h ^ 16'hA1B2, h ^ 16'hC3D4, h ^ 16'hE5F6, h ^ 16'h1788};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] be);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] sram_rd(input logic [9:0] i);
        return sram_wr[i] ? sram[i] : init_line(i);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [9:0] i);
        return ref_wr[i] ? ref_mem[i] : init_line(i);
    endfunction

    // SRAM macro model: read data at T+1, junk on cycles without a read.
    always @(posedge clk) begin
        if (bus.isram_cs && bus.isram_we) begin
            sram[bus.isram_adr[9:0]]    <= merge(sram_rd(bus.isram_adr[9:0]), bus.isram_wdata, bus.isram_be);
            sram_wr[bus.isram_adr[9:0]] <= 1'b1;
            bus.isram_rdata             <= 64'hDEAD_BEEF_DEAD_BEEF;
        end else if (bus.isram_cs) begin
            bus.isram_rdata <= sram_rd(bus.isram_adr[9:0]);
        end else begin
            bus.isram_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    // Expected instruction for a fetch PC, from the reference memory.
    function automatic logic [31:0] exp_instr(input logic [30:0] p);
        logic [28:0] lo;
        logic [28:0] hi;
        logic [63:0] l;
        logic [63:0] h;
        lo = p[30:2];
        hi = lo + 29'd1;
        l  = ref_rd(lo[9:0]);
        h  = ref_rd(hi[9:0]);
        case (p[1:0])
            2'd0:    return l[31:0];
            2'd1:    return l[47:16];
            2'd2:    return l[63:32];
            default: return {h[15:0], l[63:48]};
        endcase
    endfunction

    // ---------------- scoreboard / bookkeeping ----------------
    logic [31:0] fe_q[$];
    logic [63:0] ls_q[$];
    logic [28:0] rd_log[$];
    logic        gnt_log[$];   // 1 = fetch grant, 0 = ls grant
    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int rd_cnt = 0;
    int fe_vld_cnt = 0;
    int last_gnt_cyc = 0;
    int last_vld_cyc = 0;
    logic cur_fe_gnt = 1'b0;
    logic cur_ls_gnt = 1'b0;
    logic cs_at_gnt = 1'b0;
    logic [31:0] last_instr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        if (bus.fe_flush) fe_q.delete();
        cur_fe_gnt = bus.fe_gnt;
        cur_ls_gnt = bus.ls_gnt;
        if (bus.fe_vld || bus.ls_rvld)
            check("vld_overlap", {63'b0, bus.fe_vld & bus.ls_rvld}, 64'd0);
        if (bus.fe_vld) begin
            fe_vld_cnt++;
            last_vld_cyc = cyc_n;
            last_instr   = bus.fe_instr;
            check("fe_vld_pending", {63'b0, fe_q.size() != 0}, 64'd1);
            if (fe_q.size() != 0) check("fe_instr", {32'b0, bus.fe_instr}, {32'b0, fe_q.pop_front()});
        end
        if (bus.ls_rvld) begin
            check("ls_rvld_pending", {63'b0, ls_q.size() != 0}, 64'd1);
            if (ls_q.size() != 0) check("ls_rdata", bus.ls_rdata, ls_q.pop_front());
        end
        if (bus.isram_cs && !bus.isram_we) begin
            rd_cnt++;
            rd_log.push_back(bus.isram_adr);
        end
        if (bus.fe_gnt) begin
            last_gnt_cyc = cyc_n;
            cs_at_gnt    = bus.isram_cs;
            fe_q.push_back(exp_instr(bus.fe_pc));
            gnt_log.push_back(1'b1);
        end
        if (bus.ls_gnt) begin
            gnt_log.push_back(1'b0);
            if (bus.ls_we) begin
                ref_mem[bus.ls_adr[9:0]] = merge(ref_rd(bus.ls_adr[9:0]), bus.ls_wdata, bus.ls_be);
                ref_wr[bus.ls_adr[9:0]]  = 1'b1;
            end else begin
                ls_q.push_back(ref_rd(bus.ls_adr[9:0]));
            end
        end
    endtask

    task automatic step();
        #1;
        observe();
        @(posedge clk);
        #2;
        cyc_n++;
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    task automatic clr();
        rd_cnt = 0;
        rd_log.delete();
        fe_vld_cnt = 0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bit got;
        got = 1'b0;
        bus.fe_req = 1'b1;
        bus.fe_pc  = pc[31:1];
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = cur_fe_gnt;
        end
        bus.fe_req = 1'b0;
        check("fe_gnt_wait", {63'b0, got}, 64'd1);
    endtask

    task automatic ls_op(input logic we, input logic [28:0] adr, input logic [7:0] be,
                         input logic [63:0] wd);
        bit got;
        got = 1'b0;
        bus.ls_req = 1'b1;
        bus.ls_we = we;
        bus.ls_adr = adr;
        bus.ls_be = be;
        bus.ls_wdata = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = cur_ls_gnt;
        end
        bus.ls_req = 1'b0;
        check("ls_gnt_wait", {63'b0, got}, 64'd1);
    endtask

    function automatic logic [63:0] rd_at(input int i);
        return (rd_log.size() > i) ? {35'b0, rd_log[i]} : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat [10];
        int vld_before;
        pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        bus.fe_req = 1'b0; bus.fe_pc = '0; bus.fe_flush = 1'b0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_adr = '0;
        bus.ls_be = '0; bus.ls_wdata = '0;

        // Reset state
        @(posedge clk);
        #3;
        check("rst_fe_gnt",   {63'b0, bus.fe_gnt},   64'd0);
        check("rst_fe_vld",   {63'b0, bus.fe_vld},   64'd0);
        check("rst_ls_gnt",   {63'b0, bus.ls_gnt},   64'd0);
        check("rst_ls_rvld",  {63'b0, bus.ls_rvld},  64'd0);
        check("rst_isram_cs", {63'b0, bus.isram_cs}, 64'd0);
        check("rst_isram_we", {63'b0, bus.isram_we}, 64'd0);
        check("rst_fe_instr", {32'b0, bus.fe_instr}, 64'd0);
        check("rst_ls_rdata", bus.ls_rdata,          64'd0);
        @(posedge clk);
        #2;
        cpurst_n = 1'b1;
        drain(2);

        // 1: miss then hit in the same line
        clr();
        fetch(32'h100);
        drain(3);
        check("t1_miss_lat", 64'(last_vld_cyc - last_gnt_cyc), 64'd1);
        fetch(32'h104);
        check("t1_hit_cs", {63'b0, cs_at_gnt}, 64'd0);
        drain(3);
        check("t1_hit_lat", 64'(last_vld_cyc - last_gnt_cyc), 64'd1);
        check("t1_rd_cnt",  64'(rd_cnt), 64'd1);
        check("t1_rd_adr",  rd_at(0), 64'h20);
        check("t1_vld_cnt", 64'(fe_vld_cnt), 64'd2);

        // 2: cross-line fetch, empty buffer for line 0x40
        clr();
        fetch(32'h206);
        drain(4);
        check("t2_lat",    64'(last_vld_cyc - last_gnt_cyc), 64'd2);
        check("t2_rd_cnt", 64'(rd_cnt), 64'd2);
        check("t2_rd_lo",  rd_at(0), 64'h40);
        check("t2_rd_hi",  rd_at(1), 64'h41);

        // 3: cross-line fetch with line 0x40 buffered
        fetch(32'h200);
        drain(3);
        clr();
        fetch(32'h206);
        drain(3);
        check("t3_lat",    64'(last_vld_cyc - last_gnt_cyc), 64'd1);
        check("t3_rd_cnt", 64'(rd_cnt), 64'd1);
        check("t3_rd_hi",  rd_at(0), 64'h41);

        // 4: ls/fe contention, streak limit 4
        gnt_log.delete();
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_adr = 29'h300;
        bus.ls_be = 8'hFF; bus.ls_wdata = 64'h0123_4567_89AB_CDEF;
        bus.fe_req = 1'b1; bus.fe_pc = 31'h80;
        drain(10);
        bus.ls_req = 1'b0; bus.fe_req = 1'b0;
        drain(4);
        check("t4_gnt_cnt", 64'(gnt_log.size()), 64'd14 - 64'd4);
        for (int i = 0; i < 10; i++)
            check($sformatf("t4_gnt_%0d", i),
                  {63'b0, (gnt_log.size() > i) ? gnt_log[i] : ~pat[i]}, {63'b0, pat[i]});

        // 5: flush in FE_HI with an ls read waiting
        clr();
        fetch(32'h30E);
        vld_before = fe_vld_cnt;
        bus.fe_flush = 1'b1;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_adr = 29'h55;
        step();
        check("t5_ls_gnt", {63'b0, cur_ls_gnt}, 64'd1);
        bus.fe_flush = 1'b0;
        bus.ls_req = 1'b0;
        drain(4);
        check("t5_rd_cnt",  64'(rd_cnt), 64'd2);
        check("t5_rd_lo",   rd_at(0), 64'h61);
        check("t5_rd_ls",   rd_at(1), 64'h55);
        check("t5_no_vld",  64'(fe_vld_cnt), 64'(vld_before));

        // 6: ls write to the buffered line invalidates it
        fetch(32'h100);
        drain(3);
        ls_op(1'b1, 29'h20, 8'h0F, 64'h1234_5678_9ABC_DEF0);
        drain(2);
        clr();
        fetch(32'h100);
        drain(3);
        check("t6_rd_cnt", 64'(rd_cnt), 64'd1);
        check("t6_rd_adr", rd_at(0), 64'h20);
        check("t6_instr",  {32'b0, last_instr}, 64'h9ABC_DEF0);

        check("fe_q_empty", 64'(fe_q.size()), 64'd0);
        check("ls_q_empty", 64'(ls_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
